id_ex_stage: RTL and testbench



---
 rtl/id_ex_stage_pkg.sv | 23 ++
 rtl/id_ex_stage_wb_bypass.sv | 14 +
 rtl/id_ex_stage.sv | 179 +++++++++++++++++
 tb/tb_id_ex_stage.sv | 318 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/id_ex_stage_pkg.sv
// Shared definitions for the ID/EX stage: bundle width default, FSM states,
// and the control-bundle bit layout that EX decodes.
package id_ex_stage_pkg;

  localparam int CTRL_W_DEF = 16;
  localparam int CNT_W      = 2;

  typedef enum logic {
    ST_RUN      = 1'b0,
    ST_LU_STALL = 1'b1
  } state_e;

  // Bit positions inside id_ctrl/ex_ctrl as consumed by EX.
  localparam int CTRL_ALU_OP_LSB  = 0;
  localparam int CTRL_ALU_OP_W    = 4;
  localparam int CTRL_ALU_SRC_IMM = 4;
  localparam int CTRL_MEM_WE      = 5;
  localparam int CTRL_BRANCH      = 6;
  localparam int CTRL_JUMP        = 7;
  localparam int CTRL_WB_SEL_LSB  = 8;
  localparam int CTRL_WB_SEL_W    = 2;

endpackage

// File: rtl/id_ex_stage_wb_bypass.sv
// WB->ID bypass: forwards the register-file write data being written this
// cycle to a source operand that reads the same register (never x0).
module wb_bypass (
  input  logic        wb_we,
  input  logic [4:0]  wb_wr,
  input  logic [31:0] wb_wd,
  input  logic [4:0]  rs,
  input  logic [31:0] rf_rd,
  output logic [31:0] rs_data
);

  assign rs_data = (wb_we && (wb_wr != 5'd0) && (wb_wr == rs)) ? wb_wd : rf_rd;

endmodule

// File: rtl/id_ex_stage.sv
// ID/EX pipeline register with WB bypass, load-use stall FSM, flush bubbles
// and external freeze.
module id_ex_stage
  import id_ex_stage_pkg::*;
#(
  parameter int CTRL_W     = CTRL_W_DEF,
  parameter int LU_BUBBLES = 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              id_valid,
  input  logic [31:0]       id_pc,
  input  logic [4:0]        id_rs1,
  input  logic [4:0]        id_rs2,
  input  logic [4:0]        id_rd,
  input  logic [31:0]       id_imm,
  input  logic [CTRL_W-1:0] id_ctrl,
  input  logic              id_is_load,
  input  logic              id_rf_we,
  input  logic [31:0]       rf_rd1,
  input  logic [31:0]       rf_rd2,
  input  logic              wb_we,
  input  logic [4:0]        wb_wr,
  input  logic [31:0]       wb_wd,
  input  logic              ex_flush,
  input  logic              ext_stall,
  output logic              id_stall,
  output logic              ex_valid,
  output logic              ex_is_load,
  output logic              ex_rf_we,
  output logic [31:0]       ex_pc,
  output logic [31:0]       ex_imm,
  output logic [31:0]       ex_rs1_data,
  output logic [31:0]       ex_rs2_data,
  output logic [4:0]        ex_rs1,
  output logic [4:0]        ex_rs2,
  output logic [4:0]        ex_rd,
  output logic [CTRL_W-1:0] ex_ctrl
);

  logic              ex_valid_q, ex_valid_d;
  logic              ex_is_load_q, ex_is_load_d;
  logic              ex_rf_we_q, ex_rf_we_d;
  logic [31:0]       ex_pc_q, ex_pc_d;
  logic [31:0]       ex_imm_q, ex_imm_d;
  logic [31:0]       ex_rs1_data_q, ex_rs1_data_d;
  logic [31:0]       ex_rs2_data_q, ex_rs2_data_d;
  logic [4:0]        ex_rs1_q, ex_rs1_d;
  logic [4:0]        ex_rs2_q, ex_rs2_d;
  logic [4:0]        ex_rd_q, ex_rd_d;
  logic [CTRL_W-1:0] ex_ctrl_q, ex_ctrl_d;
  state_e            state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;

  logic [31:0] rs1_data, rs2_data;
  logic        hazard;
  logic        bubble;

  wb_bypass u_byp_rs1 (
    .wb_we  (wb_we),
    .wb_wr  (wb_wr),
    .wb_wd  (wb_wd),
    .rs     (id_rs1),
    .rf_rd  (rf_rd1),
    .rs_data(rs1_data)
  );

  wb_bypass u_byp_rs2 (
    .wb_we  (wb_we),
    .wb_wr  (wb_wr),
    .wb_wd  (wb_wd),
    .rs     (id_rs2),
    .rf_rd  (rf_rd2),
    .rs_data(rs2_data)
  );

  assign hazard = id_valid && ex_valid_q && ex_is_load_q && (ex_rd_q != 5'd0) &&
                  ((ex_rd_q == id_rs1) || (ex_rd_q == id_rs2));

  assign bubble = ((state_q == ST_RUN) && hazard) || (state_q == ST_LU_STALL);

  // Gated by rst_n so the stall stays low for the whole reset window.
  assign id_stall = rst_n && (ext_stall || bubble);

  always_comb begin
    ex_valid_d    = ex_valid_q;
    ex_is_load_d  = ex_is_load_q;
    ex_rf_we_d    = ex_rf_we_q;
    ex_pc_d       = ex_pc_q;
    ex_imm_d      = ex_imm_q;
    ex_rs1_data_d = ex_rs1_data_q;
    ex_rs2_data_d = ex_rs2_data_q;
    ex_rs1_d      = ex_rs1_q;
    ex_rs2_d      = ex_rs2_q;
    ex_rd_d       = ex_rd_q;
    ex_ctrl_d     = ex_ctrl_q;
    state_d       = state_q;
    cnt_d         = cnt_q;

    if (ex_flush) begin
      ex_valid_d   = 1'b0;
      ex_is_load_d = 1'b0;
      ex_rf_we_d   = 1'b0;
      state_d      = ST_RUN;
      cnt_d        = '0;
    end else if (ext_stall) begin
      // Freeze: every register holds.
    end else if (bubble) begin
      ex_valid_d   = 1'b0;
      ex_is_load_d = 1'b0;
      ex_rf_we_d   = 1'b0;
      // The hazard cycle is the first bubble; LU_STALL covers the rest.
      if (state_q == ST_RUN) begin
        cnt_d = CNT_W'(LU_BUBBLES - 1);
        if (LU_BUBBLES > 1) state_d = ST_LU_STALL;
      end else begin
        cnt_d = cnt_q - CNT_W'(1);
        if (cnt_d == '0) state_d = ST_RUN;
      end
    end else begin
      ex_valid_d    = id_valid;
      ex_is_load_d  = id_valid && id_is_load;
      ex_rf_we_d    = id_valid && id_rf_we;
      ex_pc_d       = id_pc;
      ex_imm_d      = id_imm;
      ex_rs1_data_d = rs1_data;
      ex_rs2_data_d = rs2_data;
      ex_rs1_d      = id_rs1;
      ex_rs2_d      = id_rs2;
      ex_rd_d       = id_rd;
      ex_ctrl_d     = id_ctrl;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ex_valid_q    <= 1'b0;
      ex_is_load_q  <= 1'b0;
      ex_rf_we_q    <= 1'b0;
      ex_pc_q       <= '0;
      ex_imm_q      <= '0;
      ex_rs1_data_q <= '0;
      ex_rs2_data_q <= '0;
      ex_rs1_q      <= '0;
      ex_rs2_q      <= '0;
      ex_rd_q       <= '0;
      ex_ctrl_q     <= '0;
      state_q       <= ST_RUN;
      cnt_q         <= '0;
    end else begin
      ex_valid_q    <= ex_valid_d;
      ex_is_load_q  <= ex_is_load_d;
      ex_rf_we_q    <= ex_rf_we_d;
      ex_pc_q       <= ex_pc_d;
      ex_imm_q      <= ex_imm_d;
      ex_rs1_data_q <= ex_rs1_data_d;
      ex_rs2_data_q <= ex_rs2_data_d;
      ex_rs1_q      <= ex_rs1_d;
      ex_rs2_q      <= ex_rs2_d;
      ex_rd_q       <= ex_rd_d;
      ex_ctrl_q     <= ex_ctrl_d;
      state_q       <= state_d;
      cnt_q         <= cnt_d;
    end
  end

  assign ex_valid    = ex_valid_q;
  assign ex_is_load  = ex_is_load_q;
  assign ex_rf_we    = ex_rf_we_q;
  assign ex_pc       = ex_pc_q;
  assign ex_imm      = ex_imm_q;
  assign ex_rs1_data = ex_rs1_data_q;
  assign ex_rs2_data = ex_rs2_data_q;
  assign ex_rs1      = ex_rs1_q;
  assign ex_rs2      = ex_rs2_q;
  assign ex_rd       = ex_rd_q;
  assign ex_ctrl     = ex_ctrl_q;

endmodule

// File: tb/tb_id_ex_stage.sv
// Bench for id_ex_stage: two instances (LU_BUBBLES=1 and 2) on shared inputs,
// vector table, directed corner sequences and a randomized model comparison.
module tb_id_ex_stage;

  localparam int CW = 16;

  logic          clk = 1'b0;
  logic          rst_n = 1'b1;
  logic          id_valid, id_is_load, id_rf_we;
  logic [31:0]   id_pc, id_imm, rf_rd1, rf_rd2, wb_wd;
  logic [4:0]    id_rs1, id_rs2, id_rd, wb_wr;
  logic [CW-1:0] id_ctrl;
  logic          wb_we, ex_flush, ext_stall;

  logic          o1_stall, o1_valid, o1_is_load, o1_rf_we;
  logic [31:0]   o1_pc, o1_imm, o1_d1, o1_d2;
  logic [4:0]    o1_rs1, o1_rs2, o1_rd;
  logic [CW-1:0] o1_ctrl;
  logic          o2_stall, o2_valid, o2_is_load, o2_rf_we;
  logic [31:0]   o2_pc, o2_imm, o2_d1, o2_d2;
  logic [4:0]    o2_rs1, o2_rs2, o2_rd;
  logic [CW-1:0] o2_ctrl;

  logic [161:0]  o1, o2;
  assign o1 = {o1_valid, o1_is_load, o1_rf_we, o1_pc, o1_imm, o1_d1, o1_d2,
               o1_rs1, o1_rs2, o1_rd, o1_ctrl};
  assign o2 = {o2_valid, o2_is_load, o2_rf_we, o2_pc, o2_imm, o2_d1, o2_d2,
               o2_rs1, o2_rs2, o2_rd, o2_ctrl};

  always #5 clk = ~clk;

  id_ex_stage #(.CTRL_W(CW), .LU_BUBBLES(1)) dut1 (
    .clk(clk), .rst_n(rst_n), .id_valid(id_valid), .id_pc(id_pc),
    .id_rs1(id_rs1), .id_rs2(id_rs2), .id_rd(id_rd), .id_imm(id_imm),
    .id_ctrl(id_ctrl), .id_is_load(id_is_load), .id_rf_we(id_rf_we),
    .rf_rd1(rf_rd1), .rf_rd2(rf_rd2), .wb_we(wb_we), .wb_wr(wb_wr),
    .wb_wd(wb_wd), .ex_flush(ex_flush), .ext_stall(ext_stall),
    .id_stall(o1_stall), .ex_valid(o1_valid), .ex_is_load(o1_is_load),
    .ex_rf_we(o1_rf_we), .ex_pc(o1_pc), .ex_imm(o1_imm),
    .ex_rs1_data(o1_d1), .ex_rs2_data(o1_d2), .ex_rs1(o1_rs1),
    .ex_rs2(o1_rs2), .ex_rd(o1_rd), .ex_ctrl(o1_ctrl)
  );

  id_ex_stage #(.CTRL_W(CW), .LU_BUBBLES(2)) dut2 (
    .clk(clk), .rst_n(rst_n), .id_valid(id_valid), .id_pc(id_pc),
    .id_rs1(id_rs1), .id_rs2(id_rs2), .id_rd(id_rd), .id_imm(id_imm),
    .id_ctrl(id_ctrl), .id_is_load(id_is_load), .id_rf_we(id_rf_we),
    .rf_rd1(rf_rd1), .rf_rd2(rf_rd2), .wb_we(wb_we), .wb_wr(wb_wr),
    .wb_wd(wb_wd), .ex_flush(ex_flush), .ext_stall(ext_stall),
    .id_stall(o2_stall), .ex_valid(o2_valid), .ex_is_load(o2_is_load),
    .ex_rf_we(o2_rf_we), .ex_pc(o2_pc), .ex_imm(o2_imm),
    .ex_rs1_data(o2_d1), .ex_rs2_data(o2_d2), .ex_rs1(o2_rs1),
    .ex_rs2(o2_rs2), .ex_rd(o2_rd), .ex_ctrl(o2_ctrl)
  );

  int n_tests = 0;
  int n_fail  = 0;

  task automatic chk(input string name, input logic [191:0] act, input logic [191:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Reference model: EX contents plus the number of bubbles still owed.
  typedef struct {
    logic          valid, is_load, rf_we;
    logic [31:0]   pc, imm, d1, d2;
    logic [4:0]    rs1, rs2, rd;
    logic [CW-1:0] ctrl;
  } ex_t;

  ex_t mex[2];
  int  mleft[2];
  int  mlu[2] = '{1, 2};

  function automatic logic [161:0] pack(input ex_t e);
    return {e.valid, e.is_load, e.rf_we, e.pc, e.imm, e.d1, e.d2,
            e.rs1, e.rs2, e.rd, e.ctrl};
  endfunction

  function automatic logic [31:0] fwd(input logic [4:0] rs, input logic [31:0] rf);
    return (wb_we && wb_wr != 0 && wb_wr == rs) ? wb_wd : rf;
  endfunction

  function automatic logic m_haz(input int k);
    return id_valid && mex[k].valid && mex[k].is_load && mex[k].rd != 0 &&
           (mex[k].rd == id_rs1 || mex[k].rd == id_rs2);
  endfunction

  function automatic logic m_stall(input int k);
    return ext_stall || m_haz(k) || (mleft[k] > 0);
  endfunction

  task automatic m_reset();
    for (int k = 0; k < 2; k++) begin
      mex[k] = '{default: '0};
      mleft[k] = 0;
    end
  endtask

  task automatic m_adv(input int k);
    if (ex_flush) begin
      mex[k].valid = 0; mex[k].is_load = 0; mex[k].rf_we = 0;
      mleft[k] = 0;
    end else if (ext_stall) begin
      mleft[k] = mleft[k];
    end else if (mleft[k] > 0 || m_haz(k)) begin
      mex[k].valid = 0; mex[k].is_load = 0; mex[k].rf_we = 0;
      mleft[k] = (mleft[k] > 0) ? mleft[k] - 1 : mlu[k] - 1;
    end else begin
      mex[k].valid   = id_valid;
      mex[k].is_load = id_valid && id_is_load;
      mex[k].rf_we   = id_valid && id_rf_we;
      mex[k].pc = id_pc; mex[k].imm = id_imm;
      mex[k].d1 = fwd(id_rs1, rf_rd1); mex[k].d2 = fwd(id_rs2, rf_rd2);
      mex[k].rs1 = id_rs1; mex[k].rs2 = id_rs2; mex[k].rd = id_rd;
      mex[k].ctrl = id_ctrl;
    end
  endtask

  task automatic set_idle();
    id_valid = 0; id_is_load = 0; id_rf_we = 0; id_pc = 0; id_imm = 0;
    rf_rd1 = 0; rf_rd2 = 0; id_rs1 = 0; id_rs2 = 0; id_rd = 0; id_ctrl = 0;
    wb_we = 0; wb_wr = 0; wb_wd = 0; ex_flush = 0; ext_stall = 0;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    set_idle();
    rst_n = 0;
    tick();
    rst_n = 1;
    m_reset();
  endtask

  // Put a load writing x7 into ID; after one edge it sits in EX.
  task automatic load_x7();
    set_idle();
    id_valid = 1; id_is_load = 1; id_rf_we = 1; id_rd = 7;
    id_rs1 = 1; id_rs2 = 2; id_pc = 32'h100;
    tick();
  endtask

  task automatic dep_on_x7(input logic use_rs1);
    set_idle();
    id_valid = 1; id_rf_we = 1; id_rd = 9; id_pc = 32'h104;
    id_rs1 = use_rs1 ? 5'd7 : 5'd3;
    id_rs2 = use_rs1 ? 5'd3 : 5'd7;
    rf_rd1 = 32'h77; rf_rd2 = 32'h33;
  endtask

  typedef struct {
    logic        vld;
    logic [4:0]  rs1, rs2;
    logic [31:0] rf1, rf2, imm;
    logic        wbwe;
    logic [4:0]  wbwr;
    logic [31:0] wbwd;
    logic        exp_vld;
    logic [31:0] exp_d1, exp_d2;
  } vec_t;

  vec_t vecs[7];

  initial begin
    vecs[0] = '{1'b1, 5'd5,  5'd6,  32'h11, 32'h22, 32'h40, 1'b0, 5'd0,  32'h0,
                1'b1, 32'h11, 32'h22};
    vecs[1] = '{1'b1, 5'd3,  5'd5,  32'h1,  32'h0,  32'h8,  1'b1, 5'd5,  32'hDEAD,
                1'b1, 32'h1,  32'hDEAD};
    vecs[2] = '{1'b1, 5'd0,  5'd0,  32'h0,  32'h0,  32'h0,  1'b1, 5'd0,  32'hBEEF,
                1'b1, 32'h0,  32'h0};
    vecs[3] = '{1'b1, 5'd9,  5'd9,  32'h33, 32'h44, 32'h0,  1'b1, 5'd9,  32'hCAFE,
                1'b1, 32'hCAFE, 32'hCAFE};
    vecs[4] = '{1'b1, 5'd9,  5'd10, 32'h33, 32'h44, 32'h0,  1'b0, 5'd9,  32'hCAFE,
                1'b1, 32'h33, 32'h44};
    vecs[5] = '{1'b0, 5'd4,  5'd4,  32'h5,  32'h6,  32'h1,  1'b0, 5'd0,  32'h0,
                1'b0, 32'h5,  32'h6};
    vecs[6] = '{1'b1, 5'd31, 5'd1,  32'hFFFFFFFF, 32'h7, 32'hFFFFF800, 1'b1, 5'd31,
                32'h12345678, 1'b1, 32'h12345678, 32'h7};

    // Reset state, with ext_stall high to confirm id_stall stays low.
    set_idle();
    #1 rst_n = 0;
    ext_stall = 1;
    #2;
    chk("rst_out1", o1, 0);
    chk("rst_out2", o2, 0);
    chk("rst_stall1", o1_stall, 0);
    chk("rst_stall2", o2_stall, 0);
    ext_stall = 0;
    tick();
    rst_n = 1;

    // Table of single-cycle advances (no loads, so no hazards).
    for (int i = 0; i < 7; i++) begin
      set_idle();
      id_valid = vecs[i].vld; id_rf_we = 1; id_rs1 = vecs[i].rs1; id_rs2 = vecs[i].rs2;
      rf_rd1 = vecs[i].rf1; rf_rd2 = vecs[i].rf2; id_imm = vecs[i].imm;
      wb_we = vecs[i].wbwe; wb_wr = vecs[i].wbwr; wb_wd = vecs[i].wbwd;
      id_pc = 32'h1000 + 32'(i * 4);
      tick();
      chk($sformatf("vec%0d_valid", i), o1_valid, vecs[i].exp_vld);
      chk($sformatf("vec%0d_rfwe", i), o1_rf_we, vecs[i].exp_vld);
      chk($sformatf("vec%0d_d1", i), o1_d1, vecs[i].exp_d1);
      chk($sformatf("vec%0d_d2", i), o1_d2, vecs[i].exp_d2);
      chk($sformatf("vec%0d_imm", i), o1_imm, vecs[i].imm);
      chk($sformatf("vec%0d_pc", i), o1_pc, 32'h1000 + 32'(i * 4));
    end

    // Load-use with one bubble.
    do_reset();
    load_x7();
    dep_on_x7(1'b1);
    #1 chk("lu1_stall_hazard", o1_stall, 1);
    tick();
    chk("lu1_bubble", o1_valid, 0);
    chk("lu1_stall_released", o1_stall, 0);
    tick();
    chk("lu1_dep_valid", o1_valid, 1);
    chk("lu1_dep_pc", o1_pc, 32'h104);
    chk("lu1_dep_d1", o1_d1, 32'h77);

    // Load-use with two bubbles and a freeze in the middle.
    do_reset();
    load_x7();
    dep_on_x7(1'b0);
    #1 chk("lu2_stall_c1", o2_stall, 1);
    tick();
    chk("lu2_bubble1", o2_valid, 0);
    ext_stall = 1;
    #1 chk("lu2_stall_frozen", o2_stall, 1);
    tick();
    chk("lu2_frozen_valid", o2_valid, 0);
    chk("lu2_frozen_pc", o2_pc, 32'h100);
    ext_stall = 0;
    #1 chk("lu2_cnt_held", o2_stall, 1);
    tick();
    chk("lu2_bubble2", o2_valid, 0);
    #1 chk("lu2_stall_released", o2_stall, 0);
    tick();
    chk("lu2_dep_valid", o2_valid, 1);
    chk("lu2_dep_pc", o2_pc, 32'h104);
    chk("lu2_dep_d2", o2_d2, 32'h33);

    // Flush in the hazard cycle wins.
    do_reset();
    load_x7();
    dep_on_x7(1'b0);
    ex_flush = 1;
    tick();
    chk("fl_valid1", o1_valid, 0);
    chk("fl_valid2", o2_valid, 0);
    chk("fl_load2", o2_is_load, 0);
    ex_flush = 0;
    #1;
    chk("fl_stall1", o1_stall, 0);
    chk("fl_stall2", o2_stall, 0);
    tick();
    chk("fl_resume2", o2_valid, 1);

    // Asynchronous reset while dut2 is in LU_STALL.
    do_reset();
    load_x7();
    dep_on_x7(1'b1);
    tick();
    #1 chk("ar_in_stall", o2_stall, 1);
    #1 rst_n = 0;
    #1;
    chk("ar_out2", o2, 0);
    chk("ar_out1", o1, 0);
    chk("ar_stall2", o2_stall, 0);
    #2 rst_n = 1;
    tick();
    chk("ar_resume_valid", o2_valid, 1);
    chk("ar_resume_pc", o2_pc, 32'h104);
    chk("ar_resume_stall", o2_stall, 0);

    // Randomized traffic against the model, both bubble settings.
    do_reset();
    for (int c = 0; c < 400; c++) begin
      id_valid   = ($urandom_range(99) < 85);
      id_is_load = $urandom_range(1);
      id_rf_we   = $urandom_range(1);
      id_pc      = $urandom;
      id_imm     = $urandom;
      id_ctrl    = CW'($urandom);
      id_rs1     = 5'($urandom_range(7));
      id_rs2     = 5'($urandom_range(7));
      id_rd      = 5'($urandom_range(7));
      rf_rd1     = $urandom;
      rf_rd2     = $urandom;
      wb_we      = $urandom_range(1);
      wb_wr      = 5'($urandom_range(7));
      wb_wd      = $urandom;
      ex_flush   = ($urandom_range(99) < 8);
      ext_stall  = ($urandom_range(99) < 15);
      #1;
      chk($sformatf("rnd%0d_stall1", c), o1_stall, m_stall(0));
      chk($sformatf("rnd%0d_stall2", c), o2_stall, m_stall(1));
      m_adv(0);
      m_adv(1);
      tick();
      chk($sformatf("rnd%0d_ex1", c), o1, pack(mex[0]));
      chk($sformatf("rnd%0d_ex2", c), o2, pack(mex[1]));
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
